ws2812_rx: RTL and testbench

Receiver/decoder for the single-wire WS2812 LED protocol: samples a WS2812 data stream, recovers 24-bit GRB pixels, and presents them one at a time with a pixel index and a valid strobe. It is the far end of our WS2812 transmit driver. Typical uses are loopback verification of the driver on the UP5K, and letting a board act as a chain element. Runs on the 48 MHz HFOSC domain.

---
 rtl/ws2812_rx_if.sv | 29 ++
 rtl/ws2812_rx.sv | 197 +++++++++++++++++++
 tb/tb_ws2812_rx.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ws2812_rx_if.sv
// ws2812_rx_if: WS2812 serial input plus decoded-pixel output bundle.
//   master : the receiver (samples din, drives pixel/strobe outputs)
//   slave  : the pixel consumer / stimulus side (drives din)
// Handshake: pixel_valid, frame_done and error are single-cycle strobes with
// no back-pressure (there is no ready). address/red/green/blue are valid while
// pixel_valid is high and hold their value until the next pixel_valid.
interface ws2812_rx_if #(
  parameter int AW = 3
);
  logic          din;
  logic [AW-1:0] address;
  logic [7:0]    red;
  logic [7:0]    green;
  logic [7:0]    blue;
  logic          pixel_valid;
  logic          frame_done;
  logic          error;
  logic          dout;

  modport master (
    input  din,
    output address, red, green, blue, pixel_valid, frame_done, error, dout
  );

  modport slave (
    output din,
    input  address, red, green, blue, pixel_valid, frame_done, error, dout
  );
endinterface

// File: rtl/ws2812_rx.sv
// ws2812_rx: WS2812 single-wire receiver. Synchronises din, measures high and
// low pulse widths, decodes GRB pixels MSB-first and presents them with an
// index and a one-cycle strobe. A long low ends the frame; an over-long high
// is a protocol error.
// Optional cascade mode: define WS2812RX_FORWARD_EN to forward the data that
// follows the first NUM_LEDS pixels on dout (otherwise dout is tied low).
module ws2812_rx #(
  parameter int NUM_LEDS     = 8,
  parameter int SYSTEM_CLOCK = 48_000_000
) (
  input  logic        clk,
  input  logic        reset,
  ws2812_rx_if.master bus,
  output logic [1:0]  dbg_state_o
);
  localparam int AW        = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam int CLK_KHZ   = SYSTEM_CLOCK / 1000;
  // 600 ns, 2 us and 50 us in clk cycles, rounded to nearest
  localparam int T_THRESH  = (CLK_KHZ * 6 + 5000) / 10000;
  localparam int T_MAXHIGH = (CLK_KHZ * 2 + 500) / 1000;
  localparam int T_GAP     = (CLK_KHZ * 50 + 500) / 1000;
  localparam int HW        = $clog2(T_MAXHIGH + 1);
  localparam int LW        = $clog2(T_GAP + 1);
  localparam int PW        = $clog2(NUM_LEDS + 1);
`ifdef WS2812RX_FORWARD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW, S_ERR} state_t;

  state_t        state_q, state_d;
  logic          sync1_q, ds_q, ds_prev_q;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [LW-1:0] lcnt_q, lcnt_d;
  logic [4:0]    bitcnt_q, bitcnt_d;
  logic [PW-1:0] pixcnt_q, pixcnt_d;
  logic [23:0]   shift_q, shift_d;
  logic [AW-1:0] address_q, address_d;
  logic [7:0]    red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic          pv_q, pv_d, fd_q, fd_d, err_q, err_d;
  logic          fwd_q, fwd_d, dout_q, dout_d;
  logic          rise, fall, bit_val;

  assign rise = ds_q & ~ds_prev_q;
  assign fall = ~ds_q & ds_prev_q;

  // Two-flop synchroniser on din plus one delay stage for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q   <= 1'b0;
      ds_q      <= 1'b0;
      ds_prev_q <= 1'b0;
    end else begin
      sync1_q   <= bus.din;
      ds_q      <= sync1_q;
      ds_prev_q <= ds_q;
    end
  end

  // Decoder state and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      hcnt_q    <= '0;
      lcnt_q    <= '0;
      bitcnt_q  <= '0;
      pixcnt_q  <= '0;
      shift_q   <= '0;
      address_q <= '0;
      red_q     <= '0;
      green_q   <= '0;
      blue_q    <= '0;
      pv_q      <= 1'b0;
      fd_q      <= 1'b0;
      err_q     <= 1'b0;
      fwd_q     <= 1'b0;
      dout_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      hcnt_q    <= hcnt_d;
      lcnt_q    <= lcnt_d;
      bitcnt_q  <= bitcnt_d;
      pixcnt_q  <= pixcnt_d;
      shift_q   <= shift_d;
      address_q <= address_d;
      red_q     <= red_d;
      green_q   <= green_d;
      blue_q    <= blue_d;
      pv_q      <= pv_d;
      fd_q      <= fd_d;
      err_q     <= err_d;
      fwd_q     <= fwd_d;
      dout_q    <= dout_d;
    end
  end

  // Next-state: pulse measurement, bit decode, pixel/frame bookkeeping
  always_comb begin
    state_d   = state_q;
    hcnt_d    = hcnt_q;
    lcnt_d    = lcnt_q;
    bitcnt_d  = bitcnt_q;
    pixcnt_d  = pixcnt_q;
    shift_d   = shift_q;
    address_d = address_q;
    red_d     = red_q;
    green_d   = green_q;
    blue_d    = blue_q;
    pv_d      = 1'b0;
    fd_d      = 1'b0;
    err_d     = 1'b0;
    fwd_d     = fwd_q;
    bit_val   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rise) begin
          state_d = S_HIGH;
          hcnt_d  = HW'(1);
        end
      end
      S_HIGH: begin
        if (fall) begin
          bit_val = (hcnt_q >= HW'(T_THRESH));
          shift_d = {shift_q[22:0], bit_val};
          lcnt_d  = LW'(1);
          state_d = S_LOW;
          if (bitcnt_q == 5'd23) begin
            bitcnt_d = '0;
            if (pixcnt_q < PW'(NUM_LEDS)) begin
              pv_d      = 1'b1;
              address_d = AW'(pixcnt_q);
              green_d   = shift_d[23:16];
              red_d     = shift_d[15:8];
              blue_d    = shift_d[7:0];
              pixcnt_d  = pixcnt_q + PW'(1);
              // last captured pixel: everything after it belongs downstream
              if (pixcnt_q == PW'(NUM_LEDS - 1)) fwd_d = 1'b1;
            end
          end else begin
            bitcnt_d = bitcnt_q + 5'd1;
          end
        end else if (hcnt_q == HW'(T_MAXHIGH - 1)) begin
          // counter is about to reach T_MAXHIGH: pulse is too long
          err_d    = 1'b1;
          state_d  = S_ERR;
          hcnt_d   = HW'(T_MAXHIGH);
          lcnt_d   = '0;
          bitcnt_d = '0;
          pixcnt_d = '0;
          fwd_d    = 1'b0;
        end else if (hcnt_q != HW'(T_MAXHIGH)) begin
          hcnt_d = hcnt_q + HW'(1);
        end
      end
      S_LOW: begin
        if (rise) begin
          state_d = S_HIGH;
          hcnt_d  = HW'(1);
        end else if (lcnt_q == LW'(T_GAP)) begin
          state_d = S_IDLE;
          if (bitcnt_q != '0)      err_d = 1'b1;
          else if (pixcnt_q != '0) fd_d  = 1'b1;
          bitcnt_d = '0;
          pixcnt_d = '0;
          fwd_d    = 1'b0;
        end else begin
          lcnt_d = lcnt_q + LW'(1);
        end
      end
      S_ERR: begin
        // wait for a clean T_GAP of low before listening again
        if (ds_q) begin
          lcnt_d = '0;
        end else if (lcnt_q == LW'(T_GAP)) begin
          state_d = S_IDLE;
          lcnt_d  = '0;
        end else begin
          lcnt_d = lcnt_q + LW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    dout_d = FWD_EN & fwd_d & ds_q;
  end

  assign bus.address     = address_q;
  assign bus.red         = red_q;
  assign bus.green       = green_q;
  assign bus.blue        = blue_q;
  assign bus.pixel_valid = pv_q;
  assign bus.frame_done  = fd_q;
  assign bus.error       = err_q;
  assign bus.dout        = dout_q;
  assign dbg_state_o     = state_q;
endmodule

// File: tb/tb_ws2812_rx.sv
// tb_ws2812_rx: directed bench for ws2812_rx. Pixel tables and hand-written
// sequences drive the serial line; a negedge monitor logs every strobe and a
// scoreboard compares logged pixels against an expected queue.
module tb_ws2812_rx;
  localparam int NUM_LEDS = 8;
  localparam int AW       = 3;
  localparam int T0H      = 19;
  localparam int T1H      = 38;
  localparam int TBIT     = 60;
  localparam int GAP_WAIT = 2450;
`ifdef WS2812RX_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    logic [7:0]    r, g, b;
  } obs_t;

  typedef struct {
    logic [7:0]    r, g, b;
    logic [AW-1:0] addr;
    logic          strobe;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] dbg_state;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  int         last_fall = 0;
  int         pix_rd = 0;
  int         dout_bad = 0;
  int         dout_high = 0;
  logic       fwd_expect = 1'b0;
  logic       exp_dout;
  logic [2:0] din_hist = '0;

  obs_t              obs_pix[$];
  int                fd_log[$];
  int                err_log[$];
  logic [AW+24-1:0]  exp_q[$];
  vec_t              vec[9];

  ws2812_rx_if #(.AW(AW)) bus();

  ws2812_rx #(.NUM_LEDS(NUM_LEDS), .SYSTEM_CLOCK(48_000_000)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .dbg_state_o(dbg_state)
  );

  // clock / reset-independent bookkeeping
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) din_hist <= {din_hist[1:0], bus.din};

  // monitor: log strobes, track dout against the expected forwarding window
  always @(negedge clk) begin
    obs_t o;
    if (bus.pixel_valid) begin
      o.cyc = cyc; o.addr = bus.address;
      o.r = bus.red; o.g = bus.green; o.b = bus.blue;
      obs_pix.push_back(o);
    end
    if (bus.frame_done) fd_log.push_back(cyc);
    if (bus.error) err_log.push_back(cyc);
    if (!reset) begin
      exp_dout = (FWD && fwd_expect) ? din_hist[2] : 1'b0;
      if (bus.dout !== exp_dout) dout_bad++;
      if (bus.dout === 1'b1) dout_high++;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic int pix_cyc(input int idx);
    return (idx < obs_pix.size()) ? obs_pix[idx].cyc : -1;
  endfunction

  function automatic int fd_cyc(input int idx);
    return (idx < fd_log.size()) ? fd_log[idx] : -1;
  endfunction

  function automatic int err_cyc(input int idx);
    return (idx < err_log.size()) ? err_log[idx] : -1;
  endfunction

  // scoreboard: new logged pixels against the expected queue
  task automatic score_pixels(input string nm);
    obs_t             o;
    logic [AW+24-1:0] w;
    check({nm, "_pix_count"}, obs_pix.size() - pix_rd, exp_q.size());
    while (exp_q.size() > 0) begin
      w = exp_q.pop_front();
      if (pix_rd < obs_pix.size()) begin
        o = obs_pix[pix_rd];
        pix_rd++;
        check({nm, "_pix"}, {o.addr, o.r, o.g, o.b}, w);
      end
    end
    pix_rd = obs_pix.size();
  endtask

  // driver tasks (all called on a negedge)
  task automatic send_bit(input logic b);
    int h;
    h = b ? T1H : T0H;
    bus.din = 1'b1;
    repeat (h) @(negedge clk);
    bus.din = 1'b0;
    last_fall = cyc;
    repeat (TBIT - h) @(negedge clk);
  endtask

  task automatic send_pixel(input logic [23:0] grb);
    for (int i = 23; i >= 0; i--) send_bit(grb[i]);
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int f0, e0, p0, t_fall, t_rise, dh0, exp_high;
    logic [23:0] w;

    for (int i = 0; i < 9; i++)
      vec[i] = '{8'(i), 8'(i), 8'(i), AW'(i), (i < NUM_LEDS)};

    bus.din = 1'b0;
    reset   = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_address", bus.address, 0);
    check("rst_rgb", {bus.red, bus.green, bus.blue}, 0);
    check("rst_strobes", {bus.pixel_valid, bus.frame_done, bus.error}, 0);
    check("rst_dout", bus.dout, 0);
    check("rst_state", dbg_state, 0);
    reset = 1'b0;
    gap(5);

    // single pixel R=12 G=34 B=56, timing of strobe and frame_done
    f0 = fd_log.size(); e0 = err_log.size(); p0 = obs_pix.size();
    exp_q.push_back({3'd0, 8'h12, 8'h34, 8'h56});
    send_pixel(24'h341256);
    t_fall = last_fall;
    gap(GAP_WAIT);
    check("single_pv_cycle", pix_cyc(p0), t_fall + 3);
    score_pixels("single");
    check("single_fd_count", fd_log.size() - f0, 1);
    check("single_fd_cycle", fd_cyc(f0), t_fall + 2403);
    check("single_err_count", err_log.size() - e0, 0);
    check("single_hold", {bus.address, bus.red, bus.green, bus.blue}, {3'd0, 24'h123456});

    // full frame from the table, twice
    for (int rep = 0; rep < 2; rep++) begin
      f0 = fd_log.size(); e0 = err_log.size();
      for (int i = 0; i < NUM_LEDS; i++) begin
        if (vec[i].strobe) exp_q.push_back({vec[i].addr, vec[i].r, vec[i].g, vec[i].b});
        send_pixel({vec[i].g, vec[i].r, vec[i].b});
      end
      gap(GAP_WAIT);
      score_pixels($sformatf("frame%0d", rep));
      check($sformatf("frame%0d_fd_count", rep), fd_log.size() - f0, 1);
      check($sformatf("frame%0d_err_count", rep), err_log.size() - e0, 0);
    end

    // partial pixel (10 bits) then gap: error instead of frame_done
    f0 = fd_log.size(); e0 = err_log.size();
    w = 24'hA5C3F0;
    for (int i = 23; i >= 14; i--) send_bit(w[i]);
    t_fall = last_fall;
    gap(GAP_WAIT);
    score_pixels("partial");
    check("partial_err_count", err_log.size() - e0, 1);
    check("partial_err_cycle", err_cyc(e0), t_fall + 2403);
    check("partial_fd_count", fd_log.size() - f0, 0);
    f0 = fd_log.size();
    exp_q.push_back({3'd0, 8'hC0, 8'h11, 8'hEE});
    send_pixel(24'h11C0EE);
    gap(GAP_WAIT);
    score_pixels("after_partial");
    check("after_partial_fd", fd_log.size() - f0, 1);

    // over-long high pulse mid-pixel
    f0 = fd_log.size(); e0 = err_log.size();
    for (int i = 0; i < 5; i++) send_bit(i[0]);
    bus.din = 1'b1;
    t_rise = cyc;
    gap(100);
    bus.din = 1'b0;
    gap(GAP_WAIT);
    score_pixels("longhigh");
    check("longhigh_err_count", err_log.size() - e0, 1);
    check("longhigh_err_cycle", err_cyc(e0), t_rise + 98);
    check("longhigh_fd_count", fd_log.size() - f0, 0);
    f0 = fd_log.size();
    exp_q.push_back({3'd0, 8'h0B, 8'h0A, 8'h0C});
    send_pixel(24'h0A0B0C);
    gap(GAP_WAIT);
    score_pixels("after_longhigh");
    check("after_longhigh_fd", fd_log.size() - f0, 1);

    // NUM_LEDS+1 pixels: extra pixel is absorbed or forwarded on dout
    f0 = fd_log.size(); e0 = err_log.size();
    dh0 = dout_high;
    exp_high = 0;
    for (int i = 0; i < 9; i++) begin
      if (vec[i].strobe) exp_q.push_back({vec[i].addr, vec[i].r, vec[i].g, vec[i].b});
      if (i == 8) begin
        fwd_expect = 1'b1;
        w = {vec[i].g, vec[i].r, vec[i].b};
        for (int k = 0; k < 24; k++) exp_high += w[k] ? T1H : T0H;
      end
      send_pixel({vec[i].g, vec[i].r, vec[i].b});
    end
    gap(GAP_WAIT);
    fwd_expect = 1'b0;
    score_pixels("overflow");
    check("overflow_fd_count", fd_log.size() - f0, 1);
    check("overflow_err_count", err_log.size() - e0, 0);
    check("overflow_dout_high", dout_high - dh0, FWD ? exp_high : 0);

    // reset during bit 12 of pixel 0
    f0 = fd_log.size(); e0 = err_log.size(); p0 = obs_pix.size();
    for (int i = 0; i < 12; i++) send_bit(1'b1);
    bus.din = 1'b1;
    gap(10);
    reset   = 1'b1;
    bus.din = 1'b0;
    gap(5);
    check("midrst_outputs", {bus.address, bus.red, bus.green, bus.blue}, 0);
    check("midrst_strobes", {bus.pixel_valid, bus.frame_done, bus.error, bus.dout}, 0);
    check("midrst_state", dbg_state, 0);
    reset = 1'b0;
    gap(10);
    check("midrst_no_events", (obs_pix.size() - p0) + (fd_log.size() - f0) + (err_log.size() - e0), 0);
    pix_rd = obs_pix.size();
    exp_q.push_back({3'd0, 8'hFF, 8'h00, 8'h7F});
    send_pixel(24'h00FF7F);
    gap(GAP_WAIT);
    score_pixels("after_reset");
    check("after_reset_fd", fd_log.size() - f0, 1);

    check("dout_bad_cycles", dout_bad, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
